// File: rtl/cavlc_bitstream_packer_pkg.sv
// Shared types and constants for the CAVLC bitstream packer.
package cavlc_pack_pkg;

    localparam int ACC_W     = 64;
    localparam int WORD_W    = 32;
    localparam int MAX_CHUNK = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_PAD   = 2'd2,
        S_LAST  = 2'd3
    } pack_state_e;

    function automatic logic [7:0] min_u8(input logic [7:0] a, input logic [7:0] b);
        min_u8 = (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cavlc_bitstream_packer_if.sv
// Code-input, flush and word-output handshakes of the packer.
interface cavlc_bitstream_packer_if #(
    parameter int CODE_W = 128,
    parameter int LEN_W  = 7,
    parameter int WORD_W = 32
);

    logic              cavlc_enc_valid;
    logic [CODE_W-1:0] cavlc_bitstream_code;
    logic [LEN_W-1:0]  cavlc_bitstream_bit;
    logic              packer_ready;
    logic              flush_req;
    logic              flush_done;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic              word_last;
    logic [2:0]        word_bytes;

    modport master (
        output cavlc_enc_valid, cavlc_bitstream_code, cavlc_bitstream_bit, flush_req, word_ready,
        input  packer_ready, flush_done, word_valid, word_data, word_last, word_bytes
    );

    modport slave (
        input  cavlc_enc_valid, cavlc_bitstream_code, cavlc_bitstream_bit, flush_req, word_ready,
        output packer_ready, flush_done, word_valid, word_data, word_last, word_bytes
    );

endinterface

// File: rtl/cavlc_bitstream_packer_bit_align.sv
// Extracts the next chunk of up to 32 code bits and positions it just below
// the accumulator fill level, producing an OR-mask for the 64-bit accumulator.
module cavlc_bit_align
    import cavlc_pack_pkg::*;
#(
    parameter int CODE_W = 128
) (
    input  logic [CODE_W-1:0] code_i,
    input  logic [7:0]        rem_i,
    input  logic [7:0]        n_i,
    input  logic [6:0]        cnt_i,
    output logic [ACC_W-1:0]  mask_o
);

    logic [MAX_CHUNK-1:0] keep_s;
    logic [MAX_CHUNK-1:0] chunk_s;
    logic [ACC_W-1:0]     wide_s;

    // Chunk bits code[rem-1 -: n] right-aligned, then MSB placed at bit 63-cnt.
    always_comb begin
        keep_s  = (n_i >= 8'd32) ? {MAX_CHUNK{1'b1}} : ((32'd1 << n_i) - 32'd1);
        chunk_s = MAX_CHUNK'(code_i >> (rem_i - n_i)) & keep_s;
        wide_s  = {chunk_s, 32'd0} << (8'd32 - n_i);
        mask_o  = wide_s >> cnt_i;
    end

endmodule

// File: rtl/cavlc_bitstream_packer.sv
// Packs right-aligned CAVLC codewords into an MSB-first stream of 32-bit words.
// Build option CAVLC_PACKER_RBSP_TRAILING_EN: the flush appends the rbsp stop bit.
module cavlc_bitstream_packer #(
    parameter int CODE_W = 128,
    parameter int LEN_W  = 7,
    parameter int WORD_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    cavlc_bitstream_packer_if.slave bus
);
    import cavlc_pack_pkg::*;

    pack_state_e       state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [7:0]        rem_q, rem_d;
    logic              done_q, done_d;

    logic [LEN_W-1:0]  len_s;
    logic              ready_s, accept_s, pop_s;
    logic              word_valid_s, word_last_s;
    logic [2:0]        word_bytes_s;
    logic [6:0]        cpost_s, pad_s;
    logic [7:0]        n_s;
    logic [ACC_W-1:0]  acc_shift_s, mask_s, stop_s;

    assign len_s       = bus.cavlc_bitstream_bit;
    assign ready_s     = (state_q == S_IDLE) && !bus.flush_req;
    assign accept_s    = bus.cavlc_enc_valid && ready_s;
    assign pop_s       = word_valid_s && bus.word_ready;
    assign cpost_s     = pop_s ? (cnt_q - 7'd32) : cnt_q;
    assign acc_shift_s = pop_s ? {acc_q[ACC_W-33:0], 32'd0} : acc_q;
    assign n_s         = min_u8(rem_q, 8'd32);

`ifdef CAVLC_PACKER_RBSP_TRAILING_EN
    assign pad_s  = 7'd8 - {4'd0, cpost_s[2:0]};
    assign stop_s = {1'b1, {(ACC_W-1){1'b0}}} >> cpost_s;
`else
    assign pad_s  = {4'd0, 3'd0 - cpost_s[2:0]};
    assign stop_s = {ACC_W{1'b0}};
`endif

    cavlc_bit_align #(.CODE_W(CODE_W)) u_align (
        .code_i (code_q),
        .rem_i  (rem_q),
        .n_i    (n_s),
        .cnt_i  (cpost_s),
        .mask_o (mask_s)
    );

    // Output word qualifiers decoded from state and fill level.
    always_comb begin
        word_valid_s = 1'b0;
        word_last_s  = 1'b0;
        word_bytes_s = 3'd0;
        case (state_q)
            S_LAST: begin
                if (cnt_q > 7'd32) begin
                    word_valid_s = 1'b1;
                    word_bytes_s = 3'd4;
                end else if (cnt_q != 7'd0) begin
                    word_valid_s = 1'b1;
                    word_last_s  = 1'b1;
                    word_bytes_s = 3'((cnt_q + 7'd7) >> 3);
                end else begin
                    word_valid_s = 1'b0;
                end
            end
            default: begin
                word_valid_s = (cnt_q >= 7'd32);
                word_bytes_s = word_valid_s ? 3'd4 : 3'd0;
            end
        endcase
    end

    // Next-state logic; a pending pop is folded into every default.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_shift_s;
        cnt_d   = cpost_s;
        code_d  = code_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done_q masks the still-held flush_req in the cycle after completion.
                if (bus.flush_req && !done_q) begin
                    state_d = S_PAD;
                end else if (accept_s) begin
                    code_d  = bus.cavlc_bitstream_code;
                    rem_d   = 8'(len_s);
                    state_d = (len_s != {LEN_W{1'b0}}) ? S_DRAIN : S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (cpost_s <= 7'd32) begin
                    acc_d   = acc_shift_s | mask_s;
                    cnt_d   = cpost_s + n_s[6:0];
                    rem_d   = rem_q - n_s;
                    state_d = (rem_q == n_s) ? S_IDLE : S_DRAIN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_PAD: begin
                if (cpost_s <= 7'd56) begin
                    acc_d   = acc_shift_s | stop_s;
                    cnt_d   = cpost_s + pad_s;
                    state_d = S_LAST;
                end else begin
                    state_d = S_PAD;
                end
            end
            S_LAST: begin
                if (cnt_q == 7'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (pop_s && word_last_s) begin
                    acc_d   = {ACC_W{1'b0}};
                    cnt_d   = 7'd0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LAST;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= 7'd0;
            code_q  <= {CODE_W{1'b0}};
            rem_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign bus.packer_ready = ready_s;
    assign bus.flush_done   = done_q;
    assign bus.word_valid   = word_valid_s;
    assign bus.word_data    = acc_q[ACC_W-1 -: WORD_W];
    assign bus.word_last    = word_last_s;
    assign bus.word_bytes   = word_bytes_s;

endmodule

// File: doc/cavlc_bitstream_packer.md
# cavlc_bitstream_packer

Packs variable-length CAVLC codewords into a continuous MSB-first stream of 32-bit words for the slice output path. Sits directly downstream of the CAVLC encoder stage: consumes its `cavlc_bitstream_code`/`cavlc_bitstream_bit`/`cavlc_enc_valid` outputs and drives its `packer_ready` input. On a slice-end flush it appends trailing bits and emits a final partial word with a byte count.

## Interface
- `CODE_W`, 128: width of the incoming code field.
- `LEN_W`, 7: width of the code-length field.
- `WORD_W`, 32: output word width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cavlc_enc_valid` in 1: code/length valid.
- `cavlc_bitstream_code` in CODE_W: code right-aligned; bit `len-1` is sent first.
- `cavlc_bitstream_bit` in LEN_W: code length, 0..127.
- `packer_ready` out 1: packer can accept a code this cycle.
- `flush_req` in 1: slice-end request; a level, held until `flush_done`.
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `word_valid` out 1: output word valid.
- `word_ready` in 1: downstream accepts the word.
- `word_data` out WORD_W: packed bits, MSB = earliest.
- `word_last` out 1: final word of the flush.
- `word_bytes` out 3: valid bytes in `word_data`, 1..4, MSB-aligned.

## Operation
- Holding register `code_r` plus `rem_r` (8b) holds the bits of the current code not yet appended.
- Accumulator `acc` (64b) and `acc_cnt` (0..64) hold bits that have not yet been emitted.
- States: `S_IDLE`, `S_DRAIN`, `S_PAD`, `S_LAST`.
- `packer_ready = (state==S_IDLE) && !flush_req`.
- Accept = `cavlc_enc_valid && packer_ready`.
  - Load `code_r` and `rem_r = len`.
  - Go to `S_DRAIN` if `len != 0`.
  - A zero-length code is consumed and discarded; state stays `S_IDLE`.
- Pop = `word_valid && word_ready`.
  - `word_valid = acc_cnt >= 32` in every state except `S_LAST`.
  - `word_data = acc[63:32]`, `word_bytes = 4`, `word_last = 0`.
  - On pop: `acc <<= 32`, `acc_cnt -= 32`.
- Append in `S_DRAIN`:
  - `c' = acc_cnt - (pop ? 32 : 0)`.
  - If `c' <= 32`: `n = min(rem_r, 32)`; bits `code_r[rem_r-1 -: n]` go into `acc` directly below `c'`; `acc_cnt = c' + n`; `rem_r -= n`.
  - When `rem_r` reaches 0, return to `S_IDLE`.
  - Pop and append may occur in the same cycle.
- Flush:
  - `flush_req` is sampled only in `S_IDLE`, so any code in progress drains first.
  - `S_IDLE -> S_PAD`. The `S_PAD` append waits until `acc_cnt <= 56`, or `acc_cnt - 32 <= 56` when a pop occurs in the same cycle.
  - `S_PAD` appends the trailing bits (see Configuration), then goes to `S_LAST`.
  - `S_LAST` drains full words. When `acc_cnt < 32`:
    - If `acc_cnt == 0`: pulse `flush_done`, return to `S_IDLE`.
    - Otherwise: assert `word_valid` with `word_last = 1` and `word_bytes = ceil(acc_cnt/8)`. Zero bits below the valid bits are guaranteed. On pop, clear `acc`/`acc_cnt`, pulse `flush_done`, go to `S_IDLE`.
  - If the final data fills an exact full word, that word carries `word_last = 1`, `word_bytes = 4`.
- `word_data` is held stable while `word_valid && !word_ready`.

## Timing
- Reset values:
  - `state = S_IDLE`, `acc = 0`, `acc_cnt = 0`, `rem_r = 0`.
  - `packer_ready = 1` (decoded from state).
  - `word_valid = 0`, `word_data = 0`, `word_last = 0`, `word_bytes = 0`, `flush_done = 0`.
- Accept at edge T:
  - First append at T+1.
  - With an empty accumulator, a 32-bit code gives `word_valid` at T+2.
- Drain time for a code is `ceil(len/32)` append cycles when downstream never stalls; a 127-bit code occupies 4 cycles.
- `packer_ready` is low from the accept edge until the cycle after the last append.
- Reset asserted mid-operation: everything returns to reset values at once; partial data is dropped.
- Simultaneous `cavlc_enc_valid` and `flush_req` in `S_IDLE`: flush wins because `packer_ready` is low, so the code is not taken.

## Configuration
- `CAVLC_PACKER_RBSP_TRAILING_EN`
  - Defined: `S_PAD` appends `rbsp_stop_one_bit` (1), then zeros up to the next byte boundary. This is always 1..8 bits.
  - Undefined: `S_PAD` appends zeros only up to the next byte boundary. This is 0..7 bits; if already aligned, it moves straight to `S_LAST`.

## Structure
- Package `cavlc_pack_pkg`:
  - `pack_state_e` enum.
  - `ACC_W = 64`, `WORD_W = 32`, `MAX_CHUNK = 32`.
  - Helper function `min_u8`.
- Sub-module `cavlc_bit_align`: combinational. Takes `code_r`, `rem_r`, `n`, `c'` and returns the 64-bit OR-mask to merge into `acc`.
- FSM and handshakes live in the top module.

## Test plan
- 32 codes each `len=1`, `code=1`, no stall → single word `0xFFFFFFFF`, `word_bytes = 4`.
- One code `len=40`, `code=0xAB_1234_5678`, then flush, macro undefined:
  - Word 1: `0xAB123456`.
  - Word 2: `0x78000000`, `word_last = 1`, `word_bytes = 1`.
  - `flush_done` pulses one cycle after that pop.
- Same stimulus with `CAVLC_PACKER_RBSP_TRAILING_EN`:
  - Word 2: `0x78800000`, `word_bytes = 2`.
- `len=127` all-ones with `word_ready = 0` for 10 cycles:
  - `packer_ready` stays low.
  - `word_data = 0xFFFFFFFF` is held stable.
  - Once `word_ready = 1`, 3 full words emerge with no loss.
- `len=0` code → accepted in one cycle, `packer_ready` stays high, no output. Then flush with an empty accumulator and macro undefined → no word, `flush_done` pulses.
- Assert `rst` mid-drain of a 100-bit code → all outputs at reset values the same cycle; the next code packs from bit 0.
